fetch_unit: RTL and testbench

Parametrised instruction-fetch sequencer for the multicycle RISC CPU. It generalises the fixed IF1/IF2/UpdatePC fetch path in three ways:
- configurable data and address widths;
- variable-latency memory through a `mem_ready` handshake;
- branch redirect, halt, and a fetch-timeout error.

It sits between the program counter logic and the shared memory port, and hands fetched instructions to the decode state machine through a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared memory command and fetch state encodings
package cpu_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [1:0] {
    F_RST   = 2'b00,
    F_FETCH = 2'b01,
    F_HOLD  = 2'b10,
    F_HALT  = 2'b11
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer with wait states, redirect, halt and timeout
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] read_data,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
);

  localparam int              CNT_W     = $clog2(MAX_WAIT + 1);
  // Counter value seen on the last tolerated stall cycle before the timeout fires.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= F_RST;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      F_RST: state_d = F_FETCH;
      F_FETCH, F_HOLD: begin
        // Halt beats redirect, and redirect beats any data or decode handshake.
        if (halt) begin
          state_d = F_HALT;
        end else if (branch_valid) begin
          pc_d    = branch_target;
          wait_d  = '0;
          state_d = F_FETCH;
        end else if (state_q == F_FETCH) begin
          if (mem_ready) begin
            instr_d = read_data;
            pc_d    = pc_q + ADDR_W'(1);
            wait_d  = '0;
            state_d = F_HOLD;
          end else if (wait_q == LAST_WAIT) begin
            err_d   = 1'b1;
            state_d = F_HALT;
          end else begin
            wait_d = wait_q + CNT_W'(1);
          end
        end else if (instr_ready) begin
          wait_d  = '0;
          state_d = F_FETCH;
        end
      end
      default: ;
    endcase
  end

  assign mem_cmd     = (state_q == F_FETCH) ? MREAD : MNONE;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == F_HOLD);
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a behavioural fetch model
module tb_fetch_unit;

  localparam int DW       = 16;
  localparam int AW       = 9;
  localparam int MAX_WAIT = 15;
  localparam int PC_MOD   = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] read_data;
  logic          mem_ready;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic          halt;
  logic [AW-1:0] pc;
  logic          fetch_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  fetch_unit #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .RESET_PC(9'h000),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_cmd      (mem_cmd),
    .mem_addr     (mem_addr),
    .read_data    (read_data),
    .mem_ready    (mem_ready),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .halt         (halt),
    .pc           (pc),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cycle, act, exp);
    else
      n_pass++;
  endtask

  // Model: has the fetcher started, is an instruction pending, is it parked, how long has it stalled.
  bit model_ok = 0;
  bit m_started, m_have, m_halted, m_err;
  int m_pc, m_wait;
  logic [DW-1:0] m_instr;

  always @(posedge clk) begin
    cycle++;
    if (reset) begin
      model_ok = 1; m_started = 0; m_have = 0; m_halted = 0; m_err = 0;
      m_pc = 0; m_wait = 0; m_instr = '0;
    end else if (model_ok) begin
      if (!m_started) m_started = 1;
      else if (m_halted) ;
      else if (halt) begin m_halted = 1; m_have = 0; end
      else if (branch_valid) begin m_pc = int'(branch_target); m_have = 0; m_wait = 0; end
      else if (m_have) begin
        if (instr_ready) begin m_have = 0; m_wait = 0; end
      end else if (mem_ready) begin
        m_instr = read_data; m_pc = (m_pc + 1) % PC_MOD; m_have = 1; m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait == MAX_WAIT) begin m_err = 1; m_halted = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_cmd", mem_cmd, (m_started && !m_halted && !m_have) ? 2'b01 : 2'b00);
      chk("m_addr", mem_addr, m_pc);
      chk("m_pc", pc, m_pc);
      chk("m_valid", instr_valid, m_have);
      chk("m_instr", instr, m_instr);
      chk("m_err", fetch_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; mem_ready = 1; read_data = 16'hD007; instr_ready = 1;
    branch_valid = 0; branch_target = '0; halt = 0;
    tick(); tick();
    chk("rst_cmd", mem_cmd, 2'b00); chk("rst_pc", pc, 0); chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0); chk("rst_err", fetch_err, 0);

    // zero-wait memory
    reset = 0;
    tick(); chk("zw_cmd1", mem_cmd, 2'b01); chk("zw_addr1", mem_addr, 0); chk("zw_valid0", instr_valid, 0);
    tick(); chk("zw_cmd2", mem_cmd, 2'b00); chk("zw_instr", instr, 16'hD007);
    chk("zw_valid1", instr_valid, 1); chk("zw_pc1", pc, 1);
    tick(); chk("zw_cmd3", mem_cmd, 2'b01); chk("zw_addr3", mem_addr, 1);
    tick(); chk("zw_pc2", pc, 2); chk("zw_valid2", instr_valid, 1);

    // three wait states
    mem_ready = 0; read_data = 16'h1234;
    tick(); chk("ws_cmd", mem_cmd, 2'b01); chk("ws_addr", mem_addr, 2);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("ws_cmd", mem_cmd, 2'b01); chk("ws_addr", mem_addr, 2);
    end
    mem_ready = 1; instr_ready = 0;
    tick(); chk("ws_instr", instr, 16'h1234); chk("ws_pc", pc, 3); chk("ws_err", fetch_err, 0);

    // decode backpressure
    for (int i = 0; i < 5; i++) begin
      tick(); chk("bp_instr", instr, 16'h1234); chk("bp_pc", pc, 3); chk("bp_cmd", mem_cmd, 2'b00);
    end
    instr_ready = 1; mem_ready = 0;
    tick(); chk("bp_resume", mem_cmd, 2'b01); chk("bp_addr", mem_addr, 3);

    // branch with simultaneous mem_ready, then wrap
    mem_ready = 1; read_data = 16'hBEEF; branch_valid = 1; branch_target = 9'h1F0;
    tick(); chk("br_pc", pc, 9'h1F0); chk("br_valid", instr_valid, 0);
    chk("br_cmd", mem_cmd, 2'b01); chk("br_discard", instr, 16'h1234);
    branch_target = 9'h1FF; mem_ready = 0;
    tick(); chk("br_pc2", pc, 9'h1FF);
    branch_valid = 0; mem_ready = 1; read_data = 16'h0A0A; instr_ready = 0;
    tick(); chk("wrap_pc", pc, 0); chk("wrap_instr", instr, 16'h0A0A);
    branch_valid = 1; branch_target = 9'h055; instr_ready = 1;
    tick(); chk("brh_pc", pc, 9'h055); chk("brh_drop", instr_valid, 0);

    // halt beats branch in HOLD
    branch_valid = 0; read_data = 16'h7777; instr_ready = 0;
    tick(); chk("h_pc", pc, 9'h056); chk("h_instr", instr, 16'h7777);
    halt = 1; branch_valid = 1; branch_target = 9'h100;
    tick(); chk("h_pc2", pc, 9'h056); chk("h_cmd", mem_cmd, 2'b00); chk("h_valid", instr_valid, 0);
    halt = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("h_stay_pc", pc, 9'h056); chk("h_stay_cmd", mem_cmd, 2'b00);
    end
    reset = 1; branch_valid = 0;
    tick(); chk("h_rst_pc", pc, 0);

    // timeout after MAX_WAIT stalled fetch cycles
    reset = 0; mem_ready = 0; instr_ready = 1;
    tick(); chk("to_cmd0", mem_cmd, 2'b01);
    for (int i = 0; i < MAX_WAIT - 1; i++) begin
      tick(); chk("to_wait_err", fetch_err, 0); chk("to_wait_cmd", mem_cmd, 2'b01);
    end
    tick(); chk("to_err", fetch_err, 1); chk("to_cmd", mem_cmd, 2'b00);
    tick(); tick(); chk("to_sticky", fetch_err, 1);

    // reset in the middle of a fetch
    reset = 1;
    tick(); chk("mr_err_clr", fetch_err, 0);
    reset = 0;
    tick();
    branch_valid = 1; branch_target = 9'h0AA;
    tick(); branch_valid = 0;
    tick(); chk("mr_pre_pc", pc, 9'h0AA); chk("mr_pre_cmd", mem_cmd, 2'b01);
    reset = 1; mem_ready = 1;
    tick(); chk("mr_pc", pc, 0); chk("mr_cmd", mem_cmd, 2'b00);
    chk("mr_err", fetch_err, 0); chk("mr_valid", instr_valid, 0);
    reset = 0;
    tick(); tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
